// File: rtl/scalar_reduce_acc_pkg.sv
// scalar_pkg: shared defaults, FSM state encoding and parameter sanity helper
// for the scalar_reduce_acc reduction stage.
//   SIZE_ARRAY_DEF : default lanes per input beat
//   SIZE_INT_DEF   : default bits per unsigned lane product
//   state_t        : IDLE / SUM / DONE
//   acc_width_ok() : true when the accumulator can hold one full beat without loss
package scalar_pkg;

    localparam int SIZE_ARRAY_DEF = 4;
    localparam int SIZE_INT_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit acc_width_ok(input int acc_w, input int size_int, input int size_array);
        return (size_array >= 2) && (acc_w >= size_int + $clog2(size_array));
    endfunction

endpackage

// File: rtl/scalar_reduce_acc_add.sv
// scalar_acc_add: ACC_WIDTH unsigned adder, accumulator plus zero-extended lane.
// Config macro: SCALAR_ACC_SAT_EN (defined: clamp sum to all-ones on carry out;
// undefined: wrap modulo 2**ACC_WIDTH). Carry out is reported in both builds.
//   i_acc   in  ACC_WIDTH  current accumulator
//   i_lane  in  SIZE_INT   lane product, unsigned
//   o_sum   out ACC_WIDTH  next accumulator value
//   o_carry out 1          carry out of bit ACC_WIDTH-1
module scalar_acc_add #(
    parameter int ACC_WIDTH = 40,
    parameter int SIZE_INT  = 32
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [SIZE_INT-1:0]  i_lane,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_carry
);

    logic [ACC_WIDTH:0] w_raw;

    always_comb begin
        w_raw   = {1'b0, i_acc} + {{(ACC_WIDTH + 1 - SIZE_INT){1'b0}}, i_lane};
        o_carry = w_raw[ACC_WIDTH];
`ifdef SCALAR_ACC_SAT_EN
        o_sum   = o_carry ? '1 : w_raw[ACC_WIDTH-1:0];
`else
        o_sum   = w_raw[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/scalar_reduce_acc.sv
// scalar_reduce_acc: serial dot-product reduction. Accepts a beat of SIZE_ARRAY
// unsigned lane products, adds one lane per cycle into the accumulator, keeps
// accumulating across beats until one marked last, then holds the result on an
// out_valid/out_ready handshake.
// Config macro: SCALAR_ACC_SAT_EN (saturating accumulator; see scalar_acc_add).
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous active-high reset
//   in_prod    in   SIZE       packed lane products, lane i at [i*SIZE_INT +: SIZE_INT]
//   in_last    in   1          beat closes the current dot product
//   in_valid   in   1          beat valid
//   in_ready   out  1          beat can be accepted (IDLE)
//   out_result out  ACC_WIDTH  dot product, valid with out_valid
//   out_ovf    out  1          sticky overflow of the current dot product
//   out_valid  out  1          result valid
//   out_ready  in   1          consumer accepts result
module scalar_reduce_acc
    import scalar_pkg::*;
#(
    parameter int SIZE_ARRAY = SIZE_ARRAY_DEF,
    parameter int SIZE_INT   = SIZE_INT_DEF,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SIZE_ARRAY*SIZE_INT-1:0] in_prod,
    input  logic                           in_last,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACC_WIDTH-1:0]           out_result,
    output logic                           out_ovf,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int SIZE  = SIZE_ARRAY * SIZE_INT;
    localparam int CNT_W = $clog2(SIZE_ARRAY);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(SIZE_ARRAY - 1);
    localparam bit ACC_OK = acc_width_ok(ACC_WIDTH, SIZE_INT, SIZE_ARRAY);

    generate
        if (!ACC_OK) begin : g_acc_width_check
            $error("scalar_reduce_acc: ACC_WIDTH too small or SIZE_ARRAY < 2");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [SIZE-1:0]      r_prod;
    logic                 r_last;
    logic [CNT_W-1:0]     r_lane_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic [SIZE_INT-1:0]  w_lane;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;

    // Lane mux with constant slice offsets only.
    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < SIZE_ARRAY; i++) begin
            if (r_lane_cnt == CNT_W'(i)) begin
                w_lane = r_prod[i*SIZE_INT +: SIZE_INT];
            end
        end
    end

    scalar_acc_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SIZE_INT  (SIZE_INT)
    ) u_add (
        .i_acc   (r_acc),
        .i_lane  (w_lane),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_result   = '0;
        out_ovf      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SUM;
                end
            end
            SUM: begin
                if (r_lane_cnt == LANE_LAST) begin
                    w_next_state = r_last ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                out_result = r_acc;
                out_ovf    = r_ovf;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prod     <= '0;
            r_last     <= 1'b0;
            r_lane_cnt <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_prod     <= in_prod;
                        r_last     <= in_last;
                        r_lane_cnt <= '0;
                    end
                end
                SUM: begin
                    r_acc      <= w_sum;
                    r_ovf      <= r_ovf | w_carry;
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
